// File: rtl/decoder_scan_onehot.sv
// rtl/decoder_scan_onehot.sv - registered binary-to-one-hot decoder with auto-scan
//
// Purpose: decodes sel into one of N = 2^SEL_W select lines (registered), or
// in scan mode steps the active line through all N lines, holding each for
// DWELL cycles. Intended for multiplexed display digit/row drive.
//
// Ports:
//   clk    rising-edge system clock
//   rst_n  asynchronous active-low reset
//   en     output enable; 0 forces all lines inactive
//   mode   0 = direct decode of sel, 1 = auto-scan
//   hold   scan only: freezes index and dwell counter
//   sel    direct-mode select; scan start index
//   out    N select lines (one-hot, or one-cold when ACT_LOW=1)
//   idx    index currently driven
//   step   one-cycle pulse when the scan index advances
//   wrap   one-cycle pulse when the scan index wraps N-1 -> 0
module decoder_scan_onehot #(
   parameter int SEL_W   = 2,
   parameter int DWELL   = 4,
   parameter bit ACT_LOW = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic                   mode,
   input  logic                   hold,
   input  logic [SEL_W-1:0]       sel,
   output logic [(1<<SEL_W)-1:0]  out,
   output logic [SEL_W-1:0]       idx,
   output logic                   step,
   output logic                   wrap
);

   localparam int N     = 1 << SEL_W;
   // DWELL=1 still needs a 1-bit counter so the compare below stays legal;
   // it simply never leaves zero.
   localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
   localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(N - 1);
   localparam logic [N-1:0]     OUT_IDLE = {N{ACT_LOW}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_DIRECT,
      S_SCAN
   } state_t;

   state_t            state, state_nx;
   logic [SEL_W-1:0]  idx_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic [N-1:0]      out_nx;
   logic              step_nx, wrap_nx;

   // Line pattern for an index, already in output polarity.
   function automatic logic [N-1:0] line_drive(input logic [SEL_W-1:0] s);
      logic [N-1:0] v;
      v    = '0;
      v[s] = 1'b1;
      return ACT_LOW ? ~v : v;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         idx   <= '0;
         cnt   <= '0;
         out   <= OUT_IDLE;
         step  <= 1'b0;
         wrap  <= 1'b0;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
         cnt   <= cnt_nx;
         out   <= out_nx;
         step  <= step_nx;
         wrap  <= wrap_nx;
      end
   end

   // Outputs are computed as next-state values so out, idx, step and wrap
   // all change on the same edge.
   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      cnt_nx   = cnt;
      out_nx   = OUT_IDLE;
      step_nx  = 1'b0;
      wrap_nx  = 1'b0;

      if (!en) begin
         // idx keeps its last value so software can still see where it was.
         state_nx = S_IDLE;
      end else if (!mode) begin
         state_nx = S_DIRECT;
         idx_nx   = sel;
         out_nx   = line_drive(sel);
      end else if (state != S_SCAN) begin
         // Scan (re)start: take sel as the starting line, fresh dwell count.
         state_nx = S_SCAN;
         idx_nx   = sel;
         cnt_nx   = '0;
         out_nx   = line_drive(sel);
      end else begin
         state_nx = S_SCAN;
         if (hold) begin
            out_nx = line_drive(idx);
         end else if (cnt == CNT_LAST) begin
            cnt_nx  = '0;
            idx_nx  = idx + SEL_W'(1);
            out_nx  = line_drive(idx + SEL_W'(1));
            step_nx = 1'b1;
            wrap_nx = (idx == IDX_LAST);
         end else begin
            cnt_nx = cnt + CNT_W'(1);
            out_nx = line_drive(idx);
         end
      end
   end

endmodule

// File: doc/decoder_scan_onehot.md
Name: decoder_scan_onehot

Overview:
- Parametrised, registered binary-to-one-hot decoder; successor to the combinational 2-to-4 decoder.
- Generalised to SEL_W-to-2^SEL_W with enable and optional active-low outputs.
- Adds an auto-scan mode that steps the active output through all lines at a programmable dwell, for multiplexed display digit/row drive.
- Sits between control logic and display/peripheral select lines.

Parameters:
- SEL_W, 2, select width; output count N = 2^SEL_W (legal range 1..6).
- DWELL, 4, clock cycles each line stays active in scan mode (>=1).
- ACT_LOW, 0, 1 = Out lines driven inverted (active-low select).

Ports:
- Clk  input  1  system clock, rising edge.
- Rst_n  input  1  asynchronous reset, active-low.
- En  input  1  output enable; 0 forces all lines inactive.
- Mode  input  1  0 = direct decode of Sel, 1 = auto-scan.
- Hold  input  1  scan mode only: freezes index and dwell counter.
- Sel  input  SEL_W  direct-mode select; also scan start index.
- Out  output  N  one-hot (or one-cold if ACT_LOW) select lines, registered.
- Idx  output  SEL_W  index currently driven, registered.
- Step  output  1  one-cycle pulse when scan index advances.
- Wrap  output  1  one-cycle pulse when scan index wraps N-1 -> 0.

Behaviour:
- Reset (Rst_n=0, async):
  - state = IDLE, Idx = 0, dwell counter = 0, Step = 0, Wrap = 0.
  - Out = all inactive: 0 when ACT_LOW=0, all 1s when ACT_LOW=1.
  - Reset mid-scan aborts immediately; there is no resume.
- States: IDLE, DIRECT, SCAN. Transitions are evaluated on every rising Clk edge.
  - En=0 from any state -> IDLE; Out inactive, Idx holds its last value, Step = Wrap = 0.
  - En=1, Mode=0 -> DIRECT.
  - En=1, Mode=1 -> SCAN.
- DIRECT:
  - Idx <= Sel and Out <= onehot(Sel).
  - Latency 1 cycle: a Sel change at edge k is visible after edge k+1.
  - Hold is ignored. Step = Wrap = 0.
- SCAN entry (from IDLE or DIRECT):
  - Idx <= Sel, dwell counter <= 0, Out <= onehot(Sel) on the entry edge.
  - Step = 0 on the entry edge.
- SCAN steady state:
  - When Hold=0, the dwell counter increments each cycle.
  - When the counter reaches DWELL-1, it clears to 0, Idx <= Idx+1 (mod N), Out follows, and Step = 1 for that cycle.
  - Wrap = 1 in the same cycle when the advance is N-1 -> 0.
  - Each line is therefore active for exactly DWELL cycles.
  - DWELL=1 advances every cycle, with Step held high continuously.
- Hold=1 in SCAN: counter, Idx and Out frozen; Step = Wrap = 0. Release resumes from the frozen count.
- Sel changes while in SCAN are ignored; the next scan restart samples Sel.
- Out is always exactly one active line when En=1 (never zero, never two), including on transition edges.
- Step and Wrap are registered and coincide with the edge on which Out changes.
- ACT_LOW only inverts Out. Idx, Step and Wrap are unaffected.

Test Plan:
- Reset: with SEL_W=2, ACT_LOW=0, assert Rst_n=0 mid-cycle -> Out=0000, Idx=00, Step=Wrap=0 immediately, without waiting for a clock edge.
- Direct decode: En=1, Mode=0, sweep Sel 0..3 -> Out = 0001, 0010, 0100, 1000, each one cycle after Sel is applied; Step stays 0.
- Scan with wrap: SEL_W=2, DWELL=4, Sel=2, Mode 0->1.
  - Out=0100 for 4 cycles, then 1000 for 4, then 0001.
  - Step pulses on each advance; Wrap pulses only on the 1000->0001 advance (16-cycle period).
- Hold: in scan, assert Hold for 5 cycles after the 2nd dwell cycle of Idx=1 -> Out stays 0010 for 4+5=9 cycles total; no Step during Hold.
- Enable / restart: in scan at Idx=3, drop En for 2 cycles then raise it with Sel=1 -> Out=0000 for 2 cycles, then 0010, and the scan restarts from 1.
- Active-low: ACT_LOW=1, SEL_W=3, direct Sel=5 -> Out=11011111; En=0 -> Out=11111111.
